fetch_align_buffer: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/hw_queue.sv | 82 ++++++++
 rtl/fetch_align_buffer.sv | 151 +++++++++++++++
 tb/tb_fetch_align_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/align front end.
// Provides halfword/instruction widths, the opcode-length mask and the
// compressed-instruction test used by the buffer and the queue.
package fetch_pkg;

  localparam int unsigned HW_W = 16;
  localparam int unsigned ILEN = 32;
  localparam logic [1:0]  OPC_MASK = 2'b11;

  typedef logic [HW_W-1:0] hw_t;

  // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic is_compressed(input hw_t hw);
    return (hw[1:0] & OPC_MASK) != OPC_MASK;
  endfunction

endpackage

// File: rtl/hw_queue.sv
// Halfword circular FIFO: push 0/1/2 and pop 0/1/2 halfwords per cycle.
// Ports:
//   clk, rst          clock, async active-low reset
//   flush             synchronous clear, overrides push/pop
//   push_n, push_hw0/1 number of halfwords to write; hw0 is written first
//   pop_n             number of halfwords to drop from the head
//   head_hw0/1        combinational read of head and head+1
//   count             current occupancy
module hw_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  hw_t           push_hw0,
  input  hw_t           push_hw1,
  input  logic [1:0]    pop_n,
  output hw_t           head_hw0,
  output hw_t           head_hw1,
  output logic [CW-1:0] count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned PW1 = PW + 1;

  hw_t           mem_q [DEPTH];
  hw_t           mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer advance with wrap; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + PW1'(n);
    if (s >= PW1'(DEPTH)) s = s - PW1'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Next-state for storage, pointers and count.
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_n != 2'd0) mem_d[wr_q] = push_hw0;
      if (push_n == 2'd2) mem_d[ptr_add(wr_q, 2'd1)] = push_hw1;
      wr_d  = ptr_add(wr_q, push_n);
      rd_d  = ptr_add(rd_q, pop_n);
      cnt_d = cnt_q + CW'(push_n) - CW'(pop_n);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_hw0 = mem_q[rd_q];
  assign head_hw1 = mem_q[ptr_add(rd_q, 2'd1)];
  assign count    = cnt_q;

endmodule

// File: rtl/fetch_align_buffer.sv
// Instruction-fetch front end: issues word-aligned fetches, buffers the
// returned words as halfwords and presents one realigned 16/32-bit
// instruction per handshake. A redirect flushes the buffer and restarts
// fetching at any halfword-aligned PC, discarding in-flight responses.
// Ports:
//   clk, rst                         clock, async active-low reset
//   imem_req_valid/ready/addr        word fetch request
//   imem_rsp_valid/data              in-order fetch response
//   redirect_valid/pc                taken branch/jump from EX
//   instr_valid/ready/data/pc        instruction handshake to IF/ID
//   instr_is_compressed              instr_data is a 16-bit instruction
module fetch_align_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BUF_HW   = 4,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_is_compressed
);

  localparam int unsigned HC_W = $clog2(BUF_HW + 1);
  localparam int unsigned OC_W = $clog2(MAX_OUT + 1);

  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     head_pc_q, head_pc_d;
  logic            skip_low_q, skip_low_d;
  logic [OC_W-1:0] out_cnt_q, out_cnt_d;
  logic [OC_W-1:0] dis_cnt_q, dis_cnt_d;
  logic            run_q, run_d;

  logic            flush;
  logic [1:0]      push_n, pop_n;
  hw_t             push_hw0, push_hw1;
  hw_t             h0, h1;
  logic [HC_W-1:0] hw_cnt;
  logic            head_comp_c;
  logic            head_avail_c;
  logic            req_fire_c;
  logic            instr_fire_c;
  logic            unused_c;

  assign unused_c = redirect_pc[0];

  hw_queue #(.DEPTH(BUF_HW)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_n   (push_n),
    .push_hw0 (push_hw0),
    .push_hw1 (push_hw1),
    .pop_n    (pop_n),
    .head_hw0 (h0),
    .head_hw1 (h1),
    .count    (hw_cnt)
  );

  // Issue only when every outstanding word, plus this one, has room reserved.
  assign imem_req_valid = run_q && !redirect_valid
                       && (32'(out_cnt_q) < 32'(MAX_OUT))
                       && ((32'(hw_cnt) + 32'd2 * (32'(out_cnt_q) + 32'd1)) <= 32'(BUF_HW));
  assign imem_req_addr  = fetch_addr_q;
  assign req_fire_c     = imem_req_valid && imem_req_ready;

  // Head instruction is complete once all its halfwords are buffered.
  assign head_comp_c  = is_compressed(h0);
  assign head_avail_c = head_comp_c ? (hw_cnt >= HC_W'(1)) : (hw_cnt >= HC_W'(2));
  assign instr_valid  = head_avail_c && !redirect_valid;
  assign instr_data   = !instr_valid ? 32'h0 :
                        head_comp_c  ? {16'h0, h0} : {h1, h0};
  assign instr_is_compressed = instr_valid && head_comp_c;
  assign instr_pc     = head_pc_q;
  assign instr_fire_c = instr_valid && instr_ready;

  // Next-state: request/response accounting, pop, then redirect override.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    skip_low_d   = skip_low_q;
    dis_cnt_d    = dis_cnt_q;
    run_d        = 1'b1;
    flush        = 1'b0;
    push_n       = 2'd0;
    push_hw0     = imem_rsp_data[15:0];
    push_hw1     = imem_rsp_data[31:16];
    pop_n        = 2'd0;
    out_cnt_d    = out_cnt_q + OC_W'(req_fire_c) - OC_W'(imem_rsp_valid);

    if (req_fire_c) fetch_addr_d = fetch_addr_q + 32'd4;

    if (imem_rsp_valid) begin
      if (dis_cnt_q != '0) begin
        dis_cnt_d = dis_cnt_q - OC_W'(1);
      end else if (skip_low_q) begin
        // First word after a redirect to PC[1]=1: only its upper half is live.
        push_n     = 2'd1;
        push_hw0   = imem_rsp_data[31:16];
        skip_low_d = 1'b0;
      end else begin
        push_n = 2'd2;
      end
    end

    if (instr_fire_c) begin
      pop_n     = head_comp_c ? 2'd1 : 2'd2;
      head_pc_d = head_pc_q + (head_comp_c ? 32'd2 : 32'd4);
    end

    // Every word still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      flush        = 1'b1;
      dis_cnt_d    = out_cnt_d;
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      head_pc_d    = {redirect_pc[31:1], 1'b0};
      skip_low_d   = redirect_pc[1];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      head_pc_q    <= {RESET_PC[31:1], 1'b0};
      skip_low_q   <= RESET_PC[1];
      out_cnt_q    <= '0;
      dis_cnt_q    <= '0;
      run_q        <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      skip_low_q   <= skip_low_d;
      out_cnt_q    <= out_cnt_d;
      dis_cnt_q    <= dis_cnt_d;
      run_q        <= run_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Self-checking bench for fetch_align_buffer: in-order memory model plus
// an expected-instruction scoreboard and a fetch-address model.
module tb_fetch_align_buffer;

  localparam int BUF_HW = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;

  fetch_align_buffer #(.RESET_PC(32'h0), .BUF_HW(BUF_HW), .MAX_OUT(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_req_valid      (imem_req_valid),
    .imem_req_ready      (imem_req_ready),
    .imem_req_addr       (imem_req_addr),
    .imem_rsp_valid      (imem_rsp_valid),
    .imem_rsp_data       (imem_rsp_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_data          (instr_data),
    .instr_pc            (instr_pc),
    .instr_is_compressed (instr_is_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        c;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] mem [0:255];
  logic [31:0] exp_fetch;

  bit          ready_k, rsp_k, iready_k, redir_k, track_occ;
  logic [31:0] redir_pc_k;
  int          rsp_budget;
  int          hw_model;
  int          checks;
  int          failures;

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] d, input logic c);
    exp_t e;
    e.pc = pc; e.data = d; e.c = c;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference decoder walking the memory image halfword by halfword.
  task automatic decode_push(input logic [31:0] start, input int n);
    logic [31:0] pc;
    logic [15:0] lo;
    pc = start;
    for (int i = 0; i < n; i++) begin
      lo = mem_hw(pc);
      if (lo[1:0] != 2'b11) begin
        push_exp(pc, {16'h0, lo}, 1'b1);
        pc = pc + 32'd2;
      end else begin
        push_exp(pc, {mem_hw(pc + 32'd2), lo}, 1'b0);
        pc = pc + 32'd4;
      end
    end
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic load_mixed();
    mem_clear();
    mem[0] = 32'h4501_4581; mem[1] = 32'h00A0_0093;
    mem[2] = 32'h0013_4581; mem[3] = 32'h4501_0000;
    mem[4] = 32'h0000_0013; mem[5] = 32'h4581_4501;
    mem[6] = 32'h00B0_0113; mem[7] = 32'h0000_4581;
  endtask

  // One clock: drive at negedge, score what fires at the coming posedge.
  task automatic step();
    logic [31:0] a;
    exp_t e;
    @(negedge clk);
    imem_req_ready = ready_k;
    redirect_valid = redir_k;
    redirect_pc    = redir_pc_k;
    instr_ready    = iready_k && (exp_q.size() > 0);
    if (rsp_k && pend_q.size() > 0 && rsp_budget != 0) begin
      a = pend_q[0];
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[a[9:2]];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (imem_rsp_valid) begin
      void'(pend_q.pop_front());
      if (rsp_budget > 0) rsp_budget--;
      if (track_occ) hw_model += 2;
    end
    if (imem_req_valid && imem_req_ready) begin
      checks++;
      if (imem_req_addr !== exp_fetch) begin
        failures++;
        $display("FAIL req_addr got=%h exp=%h", imem_req_addr, exp_fetch);
      end
      pend_q.push_back(imem_req_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redirect_valid) begin
      checks++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL redirect_cycle instr_valid=%b req_valid=%b exp 0 0", instr_valid, imem_req_valid);
      end
      exp_fetch = {redir_pc_k[31:2], 2'b00};
    end else if (instr_valid && instr_ready) begin
      e = exp_q.pop_front();
      checks++;
      if (instr_data !== e.data || instr_pc !== e.pc || instr_is_compressed !== e.c) begin
        failures++;
        $display("FAIL instr got data=%h pc=%h c=%b exp data=%h pc=%h c=%b",
                 instr_data, instr_pc, instr_is_compressed, e.data, e.pc, e.c);
      end
      if (track_occ) hw_model -= (e.c ? 1 : 2);
    end
    if (track_occ) begin
      checks++;
      if (hw_model + 2 * int'(pend_q.size()) > BUF_HW) begin
        failures++;
        $display("FAIL occupancy got=%0d exp<=%0d", hw_model + 2 * int'(pend_q.size()), BUF_HW);
      end
    end
    @(posedge clk);
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout remaining=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ready_k = 1'b1; rsp_k = 1'b1; iready_k = 1'b1; redir_k = 1'b0;
    redir_pc_k = 32'h0; track_occ = 1'b0; rsp_budget = -1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    pend_q.delete(); exp_q.delete();
    exp_fetch = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req valid=%b addr=%h exp 0 0", imem_req_valid, imem_req_addr);
    end
    checks++;
    if ({instr_valid, instr_data, instr_pc, instr_is_compressed} !== 66'h0) begin
      failures++;
      $display("FAIL reset_instr valid=%b data=%h pc=%h c=%b exp all 0",
               instr_valid, instr_data, instr_pc, instr_is_compressed);
    end
  endtask

  task automatic test_aligned();
    do_reset();
    mem_clear();
    mem[0] = 32'h0000_0013; mem[1] = 32'h00A0_0093;
    push_exp(32'h0, 32'h0000_0013, 1'b0);
    push_exp(32'h4, 32'h00A0_0093, 1'b0);
    run_until_done("aligned", 50);
  endtask

  task automatic test_compressed();
    do_reset();
    mem_clear();
    mem[0] = 32'h4501_4581;
    push_exp(32'h0, 32'h0000_4581, 1'b1);
    push_exp(32'h2, 32'h0000_4501, 1'b1);
    run_until_done("compressed", 50);
  endtask

  task automatic test_straddle();
    int n;
    do_reset();
    mem_clear();
    mem[0] = 32'h0013_4581; mem[1] = 32'h4501_0000;
    push_exp(32'h0, 32'h0000_4581, 1'b1);
    push_exp(32'h2, 32'h0000_0013, 1'b0);
    push_exp(32'h6, 32'h0000_4501, 1'b1);
    rsp_budget = 1;
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin step(); n++; end
    repeat (5) step();
    #1;
    checks++;
    if (instr_valid !== 1'b0 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL straddle_wait instr_valid=%b left=%0d exp 0 2", instr_valid, exp_q.size());
    end
    rsp_budget = -1;
    run_until_done("straddle", 50);
  endtask

  task automatic wait_two_outstanding(input string name);
    int n;
    n = 0;
    while (pend_q.size() < 2 && n < 20) begin step(); n++; end
    checks++;
    if (pend_q.size() != 2) begin
      failures++;
      $display("FAIL %s outstanding got=%0d exp=2", name, pend_q.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_clear();
    mem[8'h40] = 32'h4501_4581; mem[8'h41] = 32'h00A0_0093;
    rsp_k = 1'b0;
    wait_two_outstanding("redirect");
    redir_k = 1'b1; redir_pc_k = 32'h0000_0102;
    step();
    redir_k = 1'b0; rsp_k = 1'b1;
    push_exp(32'h102, 32'h0000_4501, 1'b1);
    push_exp(32'h104, 32'h00A0_0093, 1'b0);
    run_until_done("redirect", 50);
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_clear();
    mem[8'h40] = 32'h4501_4581; mem[8'h41] = 32'h00A0_0093;
    rsp_k = 1'b0;
    wait_two_outstanding("b2b");
    redir_k = 1'b1; redir_pc_k = 32'h0000_0300;
    step();
    rsp_k = 1'b1; redir_pc_k = 32'h0000_0102;
    step();
    redir_k = 1'b0;
    push_exp(32'h102, 32'h0000_4501, 1'b1);
    push_exp(32'h104, 32'h00A0_0093, 1'b0);
    run_until_done("b2b", 50);
  endtask

  task automatic test_stall();
    do_reset();
    load_mixed();
    decode_push(32'h0, 10);
    track_occ = 1'b1; hw_model = 0;
    iready_k = 1'b0;
    repeat (10) step();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || hw_model + 2 * int'(pend_q.size()) != BUF_HW) begin
      failures++;
      $display("FAIL stall_full req_valid=%b occ=%0d exp 0 %0d",
               imem_req_valid, hw_model + 2 * int'(pend_q.size()), BUF_HW);
    end
    iready_k = 1'b1;
    run_until_done("stall", 200);
    track_occ = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    load_mixed();
    decode_push(32'h0, 3);
    rsp_budget = 2;
    run_until_done("async_pre", 100);
    wait_two_outstanding("async");
    #1;
    checks++;
    if (imem_req_addr !== 32'h10 || instr_pc !== 32'h8) begin
      failures++;
      $display("FAIL async_pre_state addr=%h pc=%h exp 00000010 00000008", imem_req_addr, instr_pc);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, instr_is_compressed} !== 99'h0) begin
      failures++;
      $display("FAIL async_reset req_valid=%b addr=%h valid=%b data=%h pc=%h c=%b exp all 0",
               imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, instr_is_compressed);
    end
    pend_q.delete(); exp_q.delete();
    imem_rsp_valid = 1'b0; rsp_budget = -1; exp_fetch = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    decode_push(32'h0, 6);
    run_until_done("async_post", 100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; hw_model = 0;
    ready_k = 1'b1; rsp_k = 1'b1; iready_k = 1'b1; redir_k = 1'b0;
    redir_pc_k = 32'h0; track_occ = 1'b0; rsp_budget = -1; exp_fetch = 32'h0;
    mem_clear();
    test_reset();
    test_aligned();
    test_compressed();
    test_straddle();
    test_redirect();
    test_back_to_back();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
